// File: rtl/wr_burst_buffer.sv
// -----------------------------------------------------------------------------
// wr_burst_buffer
//
// Write-path stage behind the pixel packer. Packed words (with byte strobes)
// are buffered in an internal FIFO and drained as AXI4 write-data bursts.
// A burst is offered to the address generator with a req/ack handshake as
// soon as BURST_LEN words are buffered, or earlier with the residual words
// when the upstream closes a line (ilast_en).
//
// Parameters:
//   DSIZE     data word width (multiple of 8)
//   DEPTH     FIFO depth in words (power of two, >= BURST_LEN)
//   BURST_LEN full burst length in beats (1..256)
//
// Ports:
//   clock, rst            clock / synchronous active-high reset
//   iwr_en, idata, imask  input word, data and byte strobes (no backpressure)
//   ilast_en              end-of-line pulse
//   oreq, oreq_len, iack  burst request, awlen-encoded length, acknowledge
//   ovalid, iready        W channel handshake
//   odata, ostrb, olast   W channel payload
//   ocount                FIFO occupancy in words
//   ooverflow             sticky: a word arrived while the FIFO was full
//
// Build option:
//   WR_BURST_STRB_EN  when defined, imask is stored with each word and
//                     presented on ostrb; otherwise ostrb is all-ones.
// -----------------------------------------------------------------------------
module wr_burst_buffer #(
    parameter int DSIZE     = 256,
    parameter int DEPTH     = 64,
    parameter int BURST_LEN = 16
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       iwr_en,
    input  logic [DSIZE-1:0]           idata,
    input  logic [DSIZE/8-1:0]         imask,
    input  logic                       ilast_en,
    output logic                       oreq,
    output logic [7:0]                 oreq_len,
    input  logic                       iack,
    output logic                       ovalid,
    input  logic                       iready,
    output logic [DSIZE-1:0]           odata,
    output logic [DSIZE/8-1:0]         ostrb,
    output logic                       olast,
    output logic [$clog2(DEPTH):0]     ocount,
    output logic                       ooverflow
);

    localparam int SW = DSIZE / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = 9;              // holds 1..256

    localparam logic [CW-1:0] FULL_BURST = CW'(BURST_LEN);
    localparam logic [LW-1:0] FULL_LEN   = LW'(BURST_LEN);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;

    state_t            state;
    logic [DSIZE-1:0]  mem [DEPTH];
`ifdef WR_BURST_STRB_EN
    logic [SW-1:0]     smem [DEPTH];
`else
    logic              unused_mask;
`endif
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     uc;              // written words not yet owned by a burst
    logic              flush;
    logic [LW-1:0]     len;             // length of the burst in flight
    logic [LW-1:0]     beat;            // 1-based index of the beat on the bus

    logic              full;
    logic              wr_accept;
    logic              hs;
    logic              pop;
    logic              beat_end;
    logic              launch;
    logic              flush_clr;
    logic [LW-1:0]     launch_len;
    logic [LW-1:0]     next_beat;

`ifndef WR_BURST_STRB_EN
    assign unused_mask = ^imask;
`endif

    assign full      = (count == CW'(DEPTH));
    assign wr_accept = iwr_en && !full;
    assign hs        = ovalid && iready;
    assign ocount    = count;

    // The output register is loaded from the FIFO on iack (first beat) and on
    // every non-final beat handshake, so the bus never idles inside a burst.
    assign pop       = ((state == S_REQ) && iack) ||
                       ((state == S_DATA) && hs && !olast);
    assign beat_end  = (state == S_DATA) && hs && olast;
    assign next_beat = (state == S_REQ) ? LW'(1) : beat + LW'(1);

    // Burst launch decision; a full burst wins over the residual flush burst,
    // and flush is left pending so the remainder goes out afterwards.
    always_comb begin
        launch     = 1'b0;
        flush_clr  = 1'b0;
        launch_len = FULL_LEN;
        if (state == S_IDLE) begin
            if (uc >= FULL_BURST) begin
                launch = 1'b1;
            end else if (flush) begin
                flush_clr = 1'b1;
                if (uc != '0) begin
                    launch     = 1'b1;
                    launch_len = LW'(uc);
                end
            end
        end
    end

    // Storage has no reset; pointers and counts define what is valid.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wr_ptr]  <= idata;
`ifdef WR_BURST_STRB_EN
            smem[wr_ptr] <= imask;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            uc        <= '0;
            flush     <= 1'b0;
            len       <= '0;
            beat      <= '0;
            oreq      <= 1'b0;
            oreq_len  <= '0;
            ovalid    <= 1'b0;
            odata     <= '0;
            ostrb     <= '0;
            olast     <= 1'b0;
            ooverflow <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)       rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_accept) - CW'(pop);
            uc    <= uc + CW'(wr_accept) - (launch ? CW'(launch_len) : '0);

            if (iwr_en && full) ooverflow <= 1'b1;

            // A new line end outranks the clear, so it is never lost.
            if (ilast_en)       flush <= 1'b1;
            else if (flush_clr) flush <= 1'b0;

`ifndef WR_BURST_STRB_EN
            ostrb <= '1;
`endif
            if (pop) begin
                odata <= mem[rd_ptr];
`ifdef WR_BURST_STRB_EN
                ostrb <= smem[rd_ptr];
`endif
                olast <= (next_beat == len);
                beat  <= next_beat;
            end

            case (state)
                S_IDLE: begin
                    if (launch) begin
                        len      <= launch_len;
                        oreq     <= 1'b1;
                        oreq_len <= 8'(launch_len - LW'(1));
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (iack) begin
                        oreq   <= 1'b0;
                        ovalid <= 1'b1;
                        state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (beat_end) begin
                        ovalid <= 1'b0;
                        olast  <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_burst_buffer.sv
// -----------------------------------------------------------------------------
// tb_wr_burst_buffer
//
// Directed bench for wr_burst_buffer with default parameters. Inputs change
// 1 time unit after the rising edge; the bus is observed on the falling edge
// inside step(), which records requests and accepted beats in queues.
// -----------------------------------------------------------------------------
module tb_wr_burst_buffer;

    localparam int DSIZE = 256;
    localparam int DEPTH = 64;
    localparam int SW    = DSIZE / 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clock = 1'b0;
    logic              rst = 1'b1;
    logic              iwr_en = 1'b0;
    logic [DSIZE-1:0]  idata = '0;
    logic [SW-1:0]     imask = '0;
    logic              ilast_en = 1'b0;
    logic              oreq;
    logic [7:0]        oreq_len;
    logic              iack = 1'b0;
    logic              ovalid;
    logic              iready = 1'b0;
    logic [DSIZE-1:0]  odata;
    logic [SW-1:0]     ostrb;
    logic              olast;
    logic [CW-1:0]     ocount;
    logic              ooverflow;

    wr_burst_buffer dut (
        .clock     (clock),
        .rst       (rst),
        .iwr_en    (iwr_en),
        .idata     (idata),
        .imask     (imask),
        .ilast_en  (ilast_en),
        .oreq      (oreq),
        .oreq_len  (oreq_len),
        .iack      (iack),
        .ovalid    (ovalid),
        .iready    (iready),
        .odata     (odata),
        .ostrb     (ostrb),
        .olast     (olast),
        .ocount    (ocount),
        .ooverflow (ooverflow)
    );

    always #5 clock = ~clock;

    int                n_chk = 0;
    int                n_err = 0;
    int                cyc = 0;
    int                first_req_cyc = -1;
    int                first_vld_cyc = -1;
    int                t16 = 0;
    logic              tog = 1'b0;
    logic [DSIZE-1:0]  beat_q [$];
    logic              last_q [$];
    logic [SW-1:0]     strb_q [$];
    logic [7:0]        req_q  [$];
    logic              stalled = 1'b0;
    logic [DSIZE-1:0]  st_data;
    logic [SW-1:0]     st_strb;
    logic              st_last;

    function automatic logic [DSIZE-1:0] wd(int k);
        return {8{32'h0BAD0000 + 32'(k)}};
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe on the falling edge, then return 1 unit after the
    // next rising edge so the caller can drive new inputs.
    task automatic step();
        @(negedge clock);
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", ovalid, 1'b1);
                chk("stall_data", odata, st_data);
                chk("stall_strb", ostrb, st_strb);
                chk("stall_last", olast, st_last);
            end
            if (oreq && first_req_cyc < 0)   first_req_cyc = cyc;
            if (ovalid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (oreq && iack) req_q.push_back(oreq_len);
            if (ovalid && iready) begin
                beat_q.push_back(odata);
                last_q.push_back(olast);
                strb_q.push_back(ostrb);
            end
            stalled = ovalid && !iready;
            st_data = odata;
            st_strb = ostrb;
            st_last = olast;
        end
        @(posedge clock);
        cyc++;
        #1;
        if (tog) iready = ~iready;
    endtask

    task automatic put(int k, logic last);
        iwr_en   = 1'b1;
        idata    = wd(k);
        imask    = SW'($urandom);
        ilast_en = last;
        step();
        iwr_en   = 1'b0;
        ilast_en = 1'b0;
    endtask

    task automatic clear_q();
        beat_q.delete();
        last_q.delete();
        strb_q.delete();
        req_q.delete();
        first_req_cyc = -1;
        first_vld_cyc = -1;
    endtask

    // Wait (bounded) for n beats, idle a few more cycles, then check the total.
    task automatic drain(int n, int budget);
        int b = 0;
        while (beat_q.size() < n && b < budget) begin
            step();
            b++;
        end
        repeat (8) step();
        chk("beat_count", beat_q.size(), n);
    endtask

    task automatic chk_beats(int base, int n, int blen);
        for (int i = 0; i < n && i < beat_q.size(); i++) begin
            chk("beat_data", beat_q[i], wd(base + i));
            chk("beat_last", last_q[i], (i % blen == blen - 1) || (i == n - 1));
`ifndef WR_BURST_STRB_EN
            chk("beat_strb", strb_q[i], {SW{1'b1}});
`endif
        end
    endtask

    initial begin
        // ---- reset state
        repeat (2) step();
        chk("rst_oreq", oreq, 1'b0);
        chk("rst_oreq_len", oreq_len, 8'd0);
        chk("rst_ovalid", ovalid, 1'b0);
        chk("rst_odata", odata, '0);
        chk("rst_ostrb", ostrb, '0);
        chk("rst_olast", olast, 1'b0);
        chk("rst_ocount", ocount, '0);
        chk("rst_ooverflow", ooverflow, 1'b0);
        rst = 1'b0;
        step();
`ifndef WR_BURST_STRB_EN
        chk("ostrb_after_rst", ostrb, {SW{1'b1}});
`endif

        // ---- 32 back-to-back words, ack/ready tied high
        iack = 1'b1;
        iready = 1'b1;
        clear_q();
        for (int k = 1; k <= 32; k++) begin
            if (k == 16) t16 = cyc;
            put(k, 1'b0);
        end
        drain(32, 200);
        chk("t1_req_count", req_q.size(), 2);
        for (int i = 0; i < req_q.size(); i++) chk("t1_req_len", req_q[i], 8'd15);
        chk_beats(1, 32, 16);
        chk("t1_oreq_latency", first_req_cyc, t16 + 2);
        chk("t1_beat_latency", first_vld_cyc, t16 + 3);
        chk("t1_ooverflow", ooverflow, 1'b0);
        chk("t1_ocount", ocount, '0);

        // ---- 5 words then end of line
        clear_q();
        for (int k = 0; k < 5; k++) put(101 + k, 1'b0);
        iwr_en = 1'b0;
        ilast_en = 1'b1;
        step();
        ilast_en = 1'b0;
        drain(5, 100);
        chk("t2_req_count", req_q.size(), 1);
        if (req_q.size() > 0) chk("t2_req_len", req_q[0], 8'd4);
        chk_beats(101, 5, 16);
        chk("t2_ocount", ocount, '0);

        // ---- 20 words, ilast_en with word 20
        clear_q();
        for (int k = 0; k < 20; k++) put(201 + k, k == 19);
        drain(20, 150);
        chk("t3_req_count", req_q.size(), 2);
        if (req_q.size() > 1) begin
            chk("t3_req_len0", req_q[0], 8'd15);
            chk("t3_req_len1", req_q[1], 8'd3);
        end
        chk_beats(201, 20, 16);

        // ---- iready toggling during a full burst
        clear_q();
        tog = 1'b1;
        for (int k = 0; k < 16; k++) put(301 + k, 1'b0);
        drain(16, 200);
        tog = 1'b0;
        iready = 1'b1;
        chk("t4_req_count", req_q.size(), 1);
        chk_beats(301, 16, 16);
        chk("t4_ocount", ocount, '0);

        // ---- overflow with iack held low
        clear_q();
        iack = 1'b0;
        for (int k = 0; k < 70; k++) put(401 + k, 1'b0);
        repeat (3) step();
        chk("t5_ocount_full", ocount, 7'd64);
        chk("t5_ooverflow", ooverflow, 1'b1);
        chk("t5_oreq_held", oreq, 1'b1);
        chk("t5_oreq_len_held", oreq_len, 8'd15);
        chk("t5_no_beats", beat_q.size(), 0);
        iack = 1'b1;
        drain(64, 400);
        chk("t5_req_count", req_q.size(), 4);
        for (int i = 0; i < req_q.size(); i++) chk("t5_req_len", req_q[i], 8'd15);
        chk_beats(401, 64, 16);
        chk("t5_ocount_end", ocount, '0);

        // ---- reset during beat 7 of 16
        clear_q();
        begin
            int b = 0;
            for (int k = 0; k < 16; k++) put(501 + k, 1'b0);
            while (beat_q.size() < 6 && b < 100) begin
                step();
                b++;
            end
        end
        chk("t6_pre_beats", beat_q.size(), 6);
        chk("t6_beat7_on_bus", odata, wd(507));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_oreq", oreq, 1'b0);
        chk("t6_oreq_len", oreq_len, 8'd0);
        chk("t6_ovalid", ovalid, 1'b0);
        chk("t6_odata", odata, '0);
        chk("t6_ostrb", ostrb, '0);
        chk("t6_olast", olast, 1'b0);
        chk("t6_ocount", ocount, '0);
        chk("t6_ooverflow", ooverflow, 1'b0);
        for (int i = 0; i < last_q.size(); i++) chk("t6_no_olast", last_q[i], 1'b0);
        clear_q();
        step();
        for (int k = 0; k < 16; k++) put(601 + k, 1'b0);
        drain(16, 150);
        chk("t6_req_count", req_q.size(), 1);
        if (req_q.size() > 0) chk("t6_req_len", req_q[0], 8'd15);
        chk_beats(601, 16, 16);
        chk("t6_ocount_end", ocount, '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wr_burst_buffer.md
# wr_burst_buffer

Write-path stage directly downstream of the pixel packer. Accepts packed DSIZE-bit words with byte strobes and end-of-line pulses, buffers them in an internal FIFO, and emits them as AXI4 write-data bursts. A burst is released to the address generator by a request/acknowledge handshake once a full burst is buffered, or earlier when a line ends.

## Interface
- DSIZE, 256: data word width; multiple of 8.
- DEPTH, 64: FIFO depth in words; power of two, at least BURST_LEN.
- BURST_LEN, 16: full burst length in beats; range 1..256.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- iwr_en  in  1  input word valid; no backpressure to the upstream stage.
- idata  in  DSIZE  input word.
- imask  in  DSIZE/8  byte strobes for idata.
- ilast_en  in  1  end-of-line pulse; closes the line.
- oreq  out  1  burst request to the address generator.
- oreq_len  out  8  burst length minus 1 (awlen encoding).
- iack  in  1  request accepted.
- ovalid  out  1  W beat valid.
- iready  in  1  W beat ready.
- odata  out  DSIZE  W data.
- ostrb  out  DSIZE/8  W strobes.
- olast  out  1  final beat of the burst.
- ocount  out  $clog2(DEPTH)+1  FIFO occupancy in words.
- ooverflow  out  1  sticky flag: an input word was dropped.

## Operation
- FIFO write on iwr_en && !full. On a write while full, the word is dropped and ooverflow is set. ooverflow clears only on rst.
- uncommitted count uc: words written but not yet assigned to a burst. +1 per accepted write; -len when a burst launches. Both can happen in the same cycle.
- Flush flag: set by ilast_en. A word written in the same cycle as ilast_en belongs to the closing line. ilast_en while the flag is already set keeps it set.
- FSM IDLE / REQ / DATA:
  - IDLE, uc >= BURST_LEN: len = BURST_LEN, go to REQ.
  - IDLE, flush set and 0 < uc < BURST_LEN: len = uc, clear flush, go to REQ.
  - IDLE, flush set and uc == 0: clear flush, stay in IDLE.
  - Full bursts take priority over the residual flush burst.
  - REQ: oreq=1, oreq_len=len-1, both held stable until iack. On iack go to DATA.
  - DATA: emit exactly len beats in FIFO order. olast is high on beat len only. After the last handshake, go to IDLE.
- Beat handshake is AXI-style: odata, ostrb and olast are held stable while ovalid && !iready.
- uc accounting guarantees the FIFO is non-empty for every DATA beat; ovalid never drops mid-burst for lack of data.
- iack outside REQ is ignored.

## Timing
- Reset values: oreq 0, oreq_len 0, ovalid 0, odata 0, ostrb 0, olast 0, ocount 0, ooverflow 0; FSM IDLE; uc 0; flush 0.
- rst mid-burst: FIFO emptied and the burst abandoned, with no olast. Outputs take reset values the cycle after rst is sampled.
- ocount updates the cycle after the write or read.
- oreq asserts the cycle after IDLE sees its launch condition on registered uc/flush.
- First ovalid asserts the cycle after iack is sampled high.
- One beat per cycle while iready=1.
- FSM is in IDLE the cycle after the olast handshake. A minimum of 1 cycle separates the last beat of one burst from the next oreq.
- Latency, full burst with iack and iready tied high: word BURST_LEN written at cycle t, oreq at t+2, first beat at t+3.

## Configuration
- WR_BURST_STRB_EN defined: imask is stored per word beside the data and presented on ostrb with its beat.
- WR_BURST_STRB_EN undefined: no strobe storage, imask is ignored, and ostrb is constant all-ones (reset value still 0, all-ones from the first cycle after reset).

## Test plan
- 32 back-to-back words, iack and iready held 1 -> two requests with oreq_len=15, 32 beats in write order, olast on beats 16 and 32, ooverflow=0.
- 5 words, then ilast_en -> one request with oreq_len=4, 5 beats, olast on beat 5, ocount returns to 0.
- 20 words with ilast_en on word 20 -> oreq_len=15 then oreq_len=3; olast on beats 16 and 20.
- iready toggled 1/0 every cycle during a 16-beat burst -> odata/ostrb/olast stable while stalled; 16 beats accepted exactly once each.
- iack held 0, 70 words written -> ocount stops at 64, ooverflow=1, words 65-70 absent from the output after iack is released.
- rst pulsed during beat 7 of 16 -> next cycle all outputs 0 and ocount=0; a following 16-word stream produces a clean oreq_len=15 burst.
